hlr_booth_seq_mult: RTL and testbench
=====================================

Name: hlr_booth_seq_mult

Overview:
- Parametrised, iterative signed hybrid-radix Booth multiplier: the successor to the combinational HLR BM mult.
- LSB bits of the multiplier are recoded in radix-8 groups; the remaining MSB bits use exact radix-4 groups.
- A runtime mode selects R8ABE2 approximation (±3C replaced) or exact ±3C.
- One partial product is accumulated per clock. Valid/ready handshakes on input and output let it sit in the test-bench datapath between the stimulus FIFO and the error-metric collector.

Parameters:
- WIDTH, 8, operand width in bits; even, ≥4.
- R8_GROUPS, 2, number of radix-8 groups at the LSB end; 0 ≤ 3*R8_GROUPS ≤ WIDTH, and (WIDTH − 3*R8_GROUPS) must be even. Any other value is an elaboration-time error.
- Derived: R4_GROUPS = (WIDTH − 3*R8_GROUPS)/2; NGRP = R8_GROUPS + R4_GROUPS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- x  in  WIDTH  signed multiplier (the recoded operand).
- y  in  WIDTH  signed multiplicand.
- approx_en  in  1  1 = R8ABE2 approximation, 0 = exact; sampled with x and y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- prod  out  2*WIDTH  signed product, modulo 2^(2*WIDTH).
- approx_hit  out  1  at least one radix-8 group was approximated.
- busy  out  1  high while in RUN or DONE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, prod=0, approx_hit=0, busy=0. Operand, count and accumulator registers are cleared. Reset wins over every other event, including mid-RUN and during a pending output.
- Recoding: xz = {x, 0} (WIDTH+1 bits).
  - Radix-8 group i (i < R8_GROUPS) = xz[3i+3:3i]; digit d = −4*g3 + 2*g2 + g1 + g0; weight 2^(3i).
  - Radix-4 group j = xz[3R+2j+2 : 3R+2j], where R = R8_GROUPS; digit d = −2*g2 + g1 + g0; weight 2^(3R+2j).
- Approx mode, radix-8 groups:
  - 0101 gives +2C; 0110 gives +4C; 1010 gives −2C; 1001 gives −4C.
  - Each such substitution sets the internal hit flag.
  - All other codes are exact.
- Exact mode: ±3C = ±(2C + C); the hit flag is never set.
- Radix-4 groups are always exact.
- PP arithmetic: y is sign-extended to a 2*WIDTH+2 internal accumulator, scaled and shifted by the group weight. prod = acc[2*WIDTH−1:0].
- Exact mode equals the true x*y for all inputs.
- FSM:
  - IDLE: in_ready=1. On in_valid & in_ready: latch x, y and approx_en; clear acc and hit; cnt=0; go to RUN.
  - RUN: in_ready=0. Each cycle add the PP for group cnt, then cnt++. On the cycle that adds group NGRP−1, go to DONE; prod and approx_hit are registered on that same edge.
  - DONE: out_valid=1; prod and approx_hit hold stable. On out_ready, go to IDLE with out_valid=0 on the next edge.
- Latency: acceptance edge E0; out_valid rises at edge E0+NGRP. Default parameters give 3 cycles.
- Throughput: at most one op per NGRP+2 cycles. in_ready stays low in DONE (no overlap).
- Back-pressure: out_ready held low keeps DONE indefinitely with prod stable. in_valid is ignored in RUN and DONE.
- Operand changes on x, y or approx_en after acceptance have no effect.
- R8_GROUPS=0 degenerates to an exact radix-4 Booth multiplier, and approx_hit stays 0.

Test Plan (WIDTH=8, R8_GROUPS=2 unless noted):
- x=3, y=5, approx_en=0 → prod=15, approx_hit=0, out_valid exactly 3 cycles after acceptance. Same operands with approx_en=1 → prod=20 (group 0110 → +4C), approx_hit=1.
- x=5, y=7: approx_en=0 → 35; approx_en=1 → 42 (1010 → −2C), approx_hit=1.
- x=−128, y=−128, approx_en=0 → prod=16384 (0x4000). x=−128, y=127 → −16256 (0xC080).
- Exhaustive 65536 pairs with approx_en=0 → prod == x*y for every pair.
- Exhaustive sweep with approx_en=1 → matches the R8ABE2 golden model. approx_hit=1 iff a radix-8 group code is in {0101, 0110, 1001, 1010}.
- Back-pressure: hold out_ready=0 for 10 cycles → prod stable, in_ready=0, in_valid pulses ignored; release → one handshake, then IDLE. Assert rst mid-RUN → next cycle out_valid=0, prod=0, in_ready=1.
- Param sweep WIDTH=16, R8_GROUPS=4 (2 radix-4 groups, latency 6) and R8_GROUPS=0 (latency 8) → exact mode random 10k pairs match x*y.

Source files
------------

// File: rtl/hlr_booth_seq_mult.sv
// Iterative signed hybrid-radix Booth multiplier: radix-8 groups (optionally R8ABE2-approximated)
// at the LSB end, exact radix-4 groups above, one partial product accumulated per clock.
module hlr_booth_seq_mult #(
   parameter int WIDTH     = 8,
   parameter int R8_GROUPS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 approx_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 approx_hit,
   output logic                 busy
);

   localparam int R4_GROUPS = (WIDTH - 3*R8_GROUPS) / 2;
   localparam int NGRP      = R8_GROUPS + R4_GROUPS;
   localparam int ACCW      = 2*WIDTH + 2;
   localparam int CW        = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(NGRP - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
   localparam logic [ACCW-1:0] ACC_ZERO = {ACCW{1'b0}};

   generate
      if (WIDTH < 4 || (WIDTH % 2) != 0 || R8_GROUPS < 0 || 3*R8_GROUPS > WIDTH ||
          ((WIDTH - 3*R8_GROUPS) % 2) != 0) begin : g_bad_params
         $error("hlr_booth_seq_mult: illegal WIDTH/R8_GROUPS combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH:0]       r_xz;
   logic [WIDTH-1:0]     r_y;
   logic                 r_approx;
   logic [CW-1:0]        r_cnt;
   logic [ACCW-1:0]      r_acc;
   logic                 r_hit;
   logic [2*WIDTH-1:0]   r_prod;
   logic                 r_approx_hit;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   int                   w_base;
   logic                 w_is_r8;
   logic [3:0]           w_code;
   logic [2:0]           w_mag;
   logic                 w_neg;
   logic                 w_hit;
   logic [ACCW-1:0]      w_ysx;
   logic [ACCW-1:0]      w_mult;
   logic [ACCW-1:0]      w_pp;
   logic [ACCW-1:0]      w_acc_nxt;
   logic                 w_last;

   // Locate the current group in {x,0}: radix-8 groups step by 3 bits, radix-4 groups by 2.
   always_comb begin
      w_is_r8 = (int'(r_cnt) < R8_GROUPS);
      if (w_is_r8) begin
         w_base = 3 * int'(r_cnt);
      end else begin
         w_base = 3*R8_GROUPS + 2*(int'(r_cnt) - R8_GROUPS);
      end
      w_code = 4'(r_xz >> w_base);
   end

   // Recode the group into a signed digit magnitude; approx mode swaps +-3C for +-2C/+-4C.
   always_comb begin
      w_mag = 3'd0;
      w_neg = 1'b0;
      w_hit = 1'b0;
      if (w_is_r8) begin
         case (w_code)
            4'b0001, 4'b0010: w_mag = 3'd1;
            4'b0011, 4'b0100: w_mag = 3'd2;
            4'b0101: begin w_mag = r_approx ? 3'd2 : 3'd3; w_hit = r_approx; end
            4'b0110: begin w_mag = r_approx ? 3'd4 : 3'd3; w_hit = r_approx; end
            4'b0111: w_mag = 3'd4;
            4'b1000: begin w_mag = 3'd4; w_neg = 1'b1; end
            4'b1001: begin w_mag = r_approx ? 3'd4 : 3'd3; w_neg = 1'b1; w_hit = r_approx; end
            4'b1010: begin w_mag = r_approx ? 3'd2 : 3'd3; w_neg = 1'b1; w_hit = r_approx; end
            4'b1011, 4'b1100: begin w_mag = 3'd2; w_neg = 1'b1; end
            4'b1101, 4'b1110: begin w_mag = 3'd1; w_neg = 1'b1; end
            default: w_mag = 3'd0;
         endcase
      end else begin
         case (w_code[2:0])
            3'b001, 3'b010: w_mag = 3'd1;
            3'b011:         w_mag = 3'd2;
            3'b100:         begin w_mag = 3'd2; w_neg = 1'b1; end
            3'b101, 3'b110: begin w_mag = 3'd1; w_neg = 1'b1; end
            default:        w_mag = 3'd0;
         endcase
      end
   end

   // Build the weighted partial product and the next accumulator value.
   always_comb begin
      w_ysx = {{(ACCW-WIDTH){r_y[WIDTH-1]}}, r_y};
      case (w_mag)
         3'd1:    w_mult = w_ysx;
         3'd2:    w_mult = w_ysx << 1;
         3'd3:    w_mult = (w_ysx << 1) + w_ysx;
         3'd4:    w_mult = w_ysx << 2;
         default: w_mult = ACC_ZERO;
      endcase
      if (w_neg) begin
         w_pp = (ACC_ZERO - w_mult) << w_base;
      end else begin
         w_pp = w_mult << w_base;
      end
      w_acc_nxt = r_acc + w_pp;
      w_last    = (r_cnt == LAST_CNT);
   end

   // Next-state logic for the IDLE/RUN/DONE handshake FSM.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_state_nxt = S_RUN;  else w_state_nxt = S_IDLE;
         S_RUN:   if (w_last)   w_state_nxt = S_DONE; else w_state_nxt = S_RUN;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture, accumulation and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xz         <= {(WIDTH+1){1'b0}};
         r_y          <= {WIDTH{1'b0}};
         r_approx     <= 1'b0;
         r_cnt        <= {CW{1'b0}};
         r_acc        <= ACC_ZERO;
         r_hit        <= 1'b0;
         r_prod       <= {(2*WIDTH){1'b0}};
         r_approx_hit <= 1'b0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_xz     <= {x, 1'b0};
                  r_y      <= y;
                  r_approx <= approx_en;
                  r_acc    <= ACC_ZERO;
                  r_hit    <= 1'b0;
                  r_cnt    <= {CW{1'b0}};
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_hit <= r_hit | w_hit;
               r_cnt <= r_cnt + CNT_ONE;
               if (w_last) begin
                  r_prod       <= w_acc_nxt[2*WIDTH-1:0];
                  r_approx_hit <= r_hit | w_hit;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign prod       = r_prod;
   assign approx_hit = r_approx_hit;

endmodule

// File: tb/tb_hlr_booth_seq_mult.sv
// Randomised self-checking bench for hlr_booth_seq_mult: default 8-bit instance plus two
// 16-bit instances (4 radix-8 groups, and pure radix-4) checked against an arithmetic model.
module tb_hlr_booth_seq_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, approx_en, out_valid, out_ready, approx_hit, busy;
   logic [7:0]  x, y;
   logic [15:0] prod;

   logic        iv16, ap16, or16;
   logic [15:0] x16, y16;
   logic        ir1, ov1, h1, b1, ir2, ov2, h2, b2;
   logic [31:0] p1, p2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hlr_booth_seq_mult #(.WIDTH(8), .R8_GROUPS(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .prod(prod),
      .approx_hit(approx_hit), .busy(busy));

   hlr_booth_seq_mult #(.WIDTH(16), .R8_GROUPS(4)) dut16_r8 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir1), .x(x16), .y(y16),
      .approx_en(ap16), .out_valid(ov1), .out_ready(or16), .prod(p1),
      .approx_hit(h1), .busy(b1));

   hlr_booth_seq_mult #(.WIDTH(16), .R8_GROUPS(0)) dut16_r4 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir2), .x(x16), .y(y16),
      .approx_en(ap16), .out_valid(ov2), .out_ready(or16), .prod(p2),
      .approx_hit(h2), .busy(b2));

   // Reference: sum of recoded digits times y, with the R8ABE2 substitution applied to radix-8 +-3 digits.
   function automatic longint model(input longint xv, input longint yv, input bit ap,
                                    input int w, input int r8, output bit hit);
      longint xzb, sum, d, c;
      sum = 0;
      hit = 1'b0;
      xzb = (xv & ((64'sd1 << w) - 64'sd1)) << 1;
      for (int i = 0; i < r8; i++) begin
         c = (xzb >> (3*i)) & 64'sd15;
         d = -4*((c >> 3) & 1) + 2*((c >> 2) & 1) + ((c >> 1) & 1) + (c & 1);
         if (ap && d == 3) begin
            hit = 1'b1;
            d = (c == 5) ? 64'sd2 : 64'sd4;
         end else if (ap && d == -3) begin
            hit = 1'b1;
            d = (c == 10) ? -64'sd2 : -64'sd4;
         end
         sum += d * yv * (64'sd1 << (3*i));
      end
      for (int j = 0; j < (w - 3*r8)/2; j++) begin
         c = (xzb >> (3*r8 + 2*j)) & 64'sd7;
         d = -2*((c >> 2) & 1) + ((c >> 1) & 1) + (c & 1);
         sum += d * yv * (64'sd1 << (3*r8 + 2*j));
      end
      return sum & ((64'sd1 << (2*w)) - 64'sd1);
   endfunction

   // One full transaction on the 8-bit instance; operands are scrambled right after acceptance.
   task automatic run8(input logic [7:0] xa, input logic [7:0] ya, input logic ap,
                       output logic [15:0] p, output logic h, output int lat, output logic rdy);
      @(negedge clk);
      rdy = in_ready;
      x = xa; y = ya; approx_en = ap; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x = 8'($urandom); y = 8'($urandom); approx_en = 1'($urandom);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      p = prod;
      h = approx_hit;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // One transaction on both 16-bit instances in parallel; latency -1 means it never completed.
   task automatic run16(input logic [15:0] xa, input logic [15:0] ya, input logic ap,
                        output logic [31:0] q1, output logic g1, output int l1,
                        output logic [31:0] q2, output logic g2, output int l2);
      int k;
      @(negedge clk);
      x16 = xa; y16 = ya; ap16 = ap; iv16 = 1'b1;
      @(posedge clk);
      #1;
      iv16 = 1'b0;
      x16 = 16'($urandom); y16 = 16'($urandom);
      l1 = -1; l2 = -1; k = 0;
      q1 = 32'd0; q2 = 32'd0; g1 = 1'b0; g2 = 1'b0;
      @(negedge clk);
      while ((l1 < 0 || l2 < 0) && k < 40) begin
         if (ov1 && l1 < 0) begin l1 = k; q1 = p1; g1 = h1; end
         if (ov2 && l2 < 0) begin l2 = k; q2 = p2; g2 = h2; end
         @(negedge clk);
         k++;
      end
      or16 = 1'b1;
      @(posedge clk);
      #1;
      or16 = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total += 5;
      if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (prod !== 16'h0000)    begin bad++; $display("FAIL reset_prod: got %h want 0000", prod); end
      if (approx_hit !== 1'b0)  begin bad++; $display("FAIL reset_hit: got %b want 0", approx_hit); end
      if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_directed();
      logic [7:0]  dx [6] = '{8'd3, 8'd3, 8'd5, 8'd5, 8'h80, 8'h80};
      logic [7:0]  dy [6] = '{8'd5, 8'd5, 8'd7, 8'd7, 8'h80, 8'h7F};
      logic        da [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] dp [6] = '{16'd15, 16'd20, 16'd35, 16'd42, 16'h4000, 16'hC080};
      logic        dh [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] p;
      logic        h, rdy;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         run8(dx[i], dy[i], da[i], p, h, lat, rdy);
         total += 4;
         if (rdy !== 1'b1) begin bad++; $display("FAIL dir_ready[%0d]: got %b want 1", i, rdy); end
         if (p !== dp[i])  begin bad++; $display("FAIL dir_prod[%0d]: got %h want %h", i, p, dp[i]); end
         if (h !== dh[i])  begin bad++; $display("FAIL dir_hit[%0d]: got %b want %b", i, h, dh[i]); end
         if (lat != 3)     begin bad++; $display("FAIL dir_latency[%0d]: got %0d want 3", i, lat); end
      end
   endtask

   task automatic test_random_exact();
      logic [7:0]  xa, ya;
      logic [15:0] p, exp_p;
      logic        h, rdy;
      int          lat;
      for (int i = 0; i < 1500; i++) begin
         xa = 8'($urandom); ya = 8'($urandom);
         exp_p = 16'(longint'($signed(xa)) * longint'($signed(ya)));
         run8(xa, ya, 1'b0, p, h, lat, rdy);
         total += 3;
         if (p !== exp_p) begin bad++; $display("FAIL exact_prod x=%h y=%h: got %h want %h", xa, ya, p, exp_p); end
         if (h !== 1'b0)  begin bad++; $display("FAIL exact_hit x=%h: got %b want 0", xa, h); end
         if (lat != 3)    begin bad++; $display("FAIL exact_latency: got %0d want 3", lat); end
      end
   endtask

   task automatic test_random_approx();
      logic [7:0]  xa, ya;
      logic [15:0] p, exp_p;
      logic        h, rdy;
      bit          exp_h;
      int          lat;
      for (int i = 0; i < 1500; i++) begin
         xa = 8'($urandom); ya = 8'($urandom);
         exp_p = 16'(model(longint'($signed(xa)), longint'($signed(ya)), 1'b1, 8, 2, exp_h));
         run8(xa, ya, 1'b1, p, h, lat, rdy);
         total += 3;
         if (p !== exp_p) begin bad++; $display("FAIL approx_prod x=%h y=%h: got %h want %h", xa, ya, p, exp_p); end
         if (h !== exp_h) begin bad++; $display("FAIL approx_hit x=%h: got %b want %b", xa, h, exp_h); end
         if (lat != 3)    begin bad++; $display("FAIL approx_latency: got %0d want 3", lat); end
      end
   endtask

   task automatic test_back_pressure();
      logic [15:0] p;
      logic        h, rdy;
      int          lat;
      @(negedge clk);
      x = 8'hF9; y = 8'd9; approx_en = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat != 3) begin bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
      for (int i = 0; i < 10; i++) begin
         total += 3;
         if (prod !== 16'hFFC1)   begin bad++; $display("FAIL bp_prod[%0d]: got %h want ffc1", i, prod); end
         if (in_ready !== 1'b0)   begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         if (out_valid !== 1'b1)  begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
         in_valid = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total += 3;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid[%0d]: got %b want 0", i, out_valid); end
         if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready[%0d]: got %b want 1", i, in_ready); end
         if (busy !== 1'b0)      begin bad++; $display("FAIL bp_release_busy[%0d]: got %b want 0", i, busy); end
      end
      run8(8'd3, 8'd5, 1'b1, p, h, lat, rdy);
      total += 2;
      if (p !== 16'd20) begin bad++; $display("FAIL bp_next_prod: got %h want 0014", p); end
      if (h !== 1'b1)   begin bad++; $display("FAIL bp_next_hit: got %b want 1", h); end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      x = 8'd77; y = 8'd33; approx_en = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total += 5;
      if (out_valid !== 1'b0)  begin bad++; $display("FAIL rstrun_out_valid: got %b want 0", out_valid); end
      if (prod !== 16'h0000)   begin bad++; $display("FAIL rstrun_prod: got %h want 0000", prod); end
      if (in_ready !== 1'b1)   begin bad++; $display("FAIL rstrun_in_ready: got %b want 1", in_ready); end
      if (approx_hit !== 1'b0) begin bad++; $display("FAIL rstrun_hit: got %b want 0", approx_hit); end
      if (busy !== 1'b0)       begin bad++; $display("FAIL rstrun_busy: got %b want 0", busy); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL rstrun_aborted[%0d]: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_param_sweep();
      logic [15:0] xa, ya;
      logic        ap, g1, g2;
      logic [31:0] q1, q2, e1, e2;
      bit          eh1, eh2;
      int          l1, l2;
      for (int i = 0; i < 300; i++) begin
         xa = 16'($urandom); ya = 16'($urandom); ap = 1'($urandom);
         e1 = 32'(model(longint'($signed(xa)), longint'($signed(ya)), ap, 16, 4, eh1));
         e2 = 32'(longint'($signed(xa)) * longint'($signed(ya)));
         eh2 = 1'b0;
         run16(xa, ya, ap, q1, g1, l1, q2, g2, l2);
         total += 6;
         if (q1 !== e1)  begin bad++; $display("FAIL w16r8_prod x=%h y=%h a=%b: got %h want %h", xa, ya, ap, q1, e1); end
         if (g1 !== eh1) begin bad++; $display("FAIL w16r8_hit x=%h a=%b: got %b want %b", xa, ap, g1, eh1); end
         if (l1 != 6)    begin bad++; $display("FAIL w16r8_latency: got %0d want 6", l1); end
         if (q2 !== e2)  begin bad++; $display("FAIL w16r4_prod x=%h y=%h: got %h want %h", xa, ya, q2, e2); end
         if (g2 !== eh2) begin bad++; $display("FAIL w16r4_hit x=%h: got %b want 0", xa, g2); end
         if (l2 != 8)    begin bad++; $display("FAIL w16r4_latency: got %0d want 8", l2); end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; approx_en = 1'b0; x = 8'd0; y = 8'd0;
      iv16 = 1'b0; or16 = 1'b0; ap16 = 1'b0; x16 = 16'd0; y16 = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_directed();
      test_random_exact();
      test_random_approx();
      test_back_pressure();
      test_reset_mid_run();
      test_param_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
